axis_rate_limit_sched: RTL and testbench
========================================

Name: axis_rate_limit_sched

Overview:
Frame-aware round-robin scheduler that shares a single axis_rate_limit instance among S_COUNT AXI-stream sources, each with its own rate configuration. It grants one source per frame, muxes that source's stream onto the limiter input, and drives rate_num/rate_denom/rate_by_frame with the granted source's settings, latched at grant time. It sits directly upstream of axis_rate_limit.

Parameters:
S_COUNT, 4, number of input sources (2..16)
DATA_WIDTH, 64, tdata width
KEEP_WIDTH, DATA_WIDTH/8, tkeep width
ID_WIDTH, 8, tid width
DEST_WIDTH, 8, tdest width
USER_WIDTH, 1, tuser width
RATE_WIDTH, 8, width of rate_num and rate_denom

Ports:
clk  in  1  clock
rst  in  1  reset (one clock; reset is asynchronous and active-high)
s_axis_tdata  in  S_COUNT*DATA_WIDTH  per-source data, source i at slice i
s_axis_tkeep  in  S_COUNT*KEEP_WIDTH  per-source keep
s_axis_tvalid  in  S_COUNT  per-source valid
s_axis_tready  out  S_COUNT  per-source ready
s_axis_tlast  in  S_COUNT  per-source last
s_axis_tid / s_axis_tdest / s_axis_tuser  in  S_COUNT*ID/DEST/USER_WIDTH  sideband
s_rate_num  in  S_COUNT*RATE_WIDTH  per-source rate numerator
s_rate_denom  in  S_COUNT*RATE_WIDTH  per-source rate denominator
s_rate_by_frame  in  S_COUNT  per-source rate_by_frame
m_axis_tdata/tkeep/tvalid/tlast/tid/tdest/tuser  out  matching widths  to limiter input
m_axis_tready  in  1  from limiter s_axis_tready
rate_num  out  RATE_WIDTH  to limiter
rate_denom  out  RATE_WIDTH  to limiter
rate_by_frame  out  1  to limiter
grant_valid  out  1  a source currently owns the output
grant_index  out  $clog2(S_COUNT)  granted source

Behaviour:
- States: IDLE, ACTIVE. Reset (async): state=IDLE, grant_valid=0, grant_index=0, last_grant=S_COUNT-1 (source 0 wins first), rate_num=0, rate_denom=0, rate_by_frame=0; s_axis_tready=0 and m_axis_tvalid=0 immediately.
- IDLE: if any s_axis_tvalid, choose the first valid source searching from last_grant+1 upward with wrap modulo S_COUNT; at the clock edge register grant_index=last_grant=winner, grant_valid=1, and latch that source's s_rate_num/s_rate_denom/s_rate_by_frame into the rate outputs; go ACTIVE. No valid -> stay IDLE, outputs hold.
- ACTIVE: combinational mux: m_axis_* = granted source's signals; m_axis_tvalid = s_axis_tvalid[grant_index]; s_axis_tready[grant_index] = m_axis_tready; all other readys 0. Zero datapath latency, no buffering.
- On a beat with m_axis_tvalid & m_axis_tready & m_axis_tlast: grant_valid=0, return to IDLE at that edge. Arbitration costs exactly one idle cycle between frames (first beat of the next frame can transfer no earlier than 2 cycles after the previous tlast beat).
- Grant is never revoked mid-frame; if the granted source deasserts tvalid mid-frame, the grant holds.
- Rate outputs change only on a grant edge; changes on s_rate_* during a frame are ignored until that source's next grant. rate_denom=0 is passed through unchecked.
- Single requester repeatedly valid: re-granted every frame (round-robin wraps to itself).
- Reset mid-frame: grant dropped asynchronously; the partial frame is truncated (no tlast emitted); the next grant after reset goes to source 0.
- tid/tdest/tuser pass through from the granted source unchanged; no source tagging.

Test Plan:
- Reset then source 2 sends a 3-beat frame (others idle), s_rate_num[2]=1, s_rate_denom[2]=4, m_axis_tready=1 -> grant_index=2, rate_num=1, rate_denom=4 one cycle after tvalid; 3 beats out with data unchanged, tlast on beat 3, grant_valid=0 next cycle.
- S_COUNT=4, all sources continuously offering 2-beat frames -> grant order 0,1,2,3,0,...; exactly one idle cycle between frames; readys strictly one-hot.
- Source 1 changes s_rate_num from 2 to 5 mid-frame -> rate_num stays 2 until frame ends; next grant of source 1 shows 5.
- m_axis_tready toggling 1,0,1,0 during a 4-beat frame -> 4 beats accepted only on tready-high cycles, no data loss or duplication, grant held throughout.
- Assert rst during beat 2 of a 4-beat frame from source 3 -> s_axis_tready and m_axis_tvalid fall in the same cycle, rate outputs 0; after release with sources 0 and 3 valid, source 0 granted.
- Granted source drops tvalid for 3 cycles mid-frame while source 0 is valid -> no regrant; frame resumes and completes from the original source.

Source files
------------

// File: rtl/axis_rate_limit_sched.sv
// axis_rate_limit_sched
//   Frame-aware round-robin scheduler placed in front of a single
//   axis_rate_limit instance. One source owns the output per frame; its
//   stream is muxed through with zero latency and its rate settings are
//   captured at grant time.
//
// Ports
//   clk, rst                  clock, asynchronous active-high reset
//   s_axis_*                  S_COUNT packed AXI-stream sources (source i at slice i)
//   s_rate_num/denom/by_frame per-source rate configuration
//   m_axis_*                  muxed stream toward the limiter input
//   rate_num/denom/by_frame   latched rate settings of the granted source
//   grant_valid, grant_index  current owner of the output
module axis_rate_limit_sched #(
  parameter int S_COUNT    = 4,
  parameter int DATA_WIDTH = 64,
  parameter int KEEP_WIDTH = DATA_WIDTH / 8,
  parameter int ID_WIDTH   = 8,
  parameter int DEST_WIDTH = 8,
  parameter int USER_WIDTH = 1,
  parameter int RATE_WIDTH = 8,
  localparam int IDX_W     = (S_COUNT > 1) ? $clog2(S_COUNT) : 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [S_COUNT*DATA_WIDTH-1:0] s_axis_tdata,
  input  logic [S_COUNT*KEEP_WIDTH-1:0] s_axis_tkeep,
  input  logic [S_COUNT-1:0]            s_axis_tvalid,
  output logic [S_COUNT-1:0]            s_axis_tready,
  input  logic [S_COUNT-1:0]            s_axis_tlast,
  input  logic [S_COUNT*ID_WIDTH-1:0]   s_axis_tid,
  input  logic [S_COUNT*DEST_WIDTH-1:0] s_axis_tdest,
  input  logic [S_COUNT*USER_WIDTH-1:0] s_axis_tuser,
  input  logic [S_COUNT*RATE_WIDTH-1:0] s_rate_num,
  input  logic [S_COUNT*RATE_WIDTH-1:0] s_rate_denom,
  input  logic [S_COUNT-1:0]            s_rate_by_frame,
  output logic [DATA_WIDTH-1:0]         m_axis_tdata,
  output logic [KEEP_WIDTH-1:0]         m_axis_tkeep,
  output logic                          m_axis_tvalid,
  input  logic                          m_axis_tready,
  output logic                          m_axis_tlast,
  output logic [ID_WIDTH-1:0]           m_axis_tid,
  output logic [DEST_WIDTH-1:0]         m_axis_tdest,
  output logic [USER_WIDTH-1:0]         m_axis_tuser,
  output logic [RATE_WIDTH-1:0]         rate_num,
  output logic [RATE_WIDTH-1:0]         rate_denom,
  output logic                          rate_by_frame,
  output logic                          grant_valid,
  output logic [IDX_W-1:0]              grant_index
);

  localparam int unsigned NS = S_COUNT;

  typedef enum logic {IDLE, ACTIVE} state_t;

  state_t           state;
  logic [IDX_W-1:0] last_grant;

  logic                  found;
  logic [IDX_W-1:0]      winner;
  logic [RATE_WIDTH-1:0] win_num;
  logic [RATE_WIDTH-1:0] win_denom;
  logic                  win_by_frame;

  // Round-robin search starting just after last_grant; k runs to NS so the
  // previous owner is considered last and a lone requester wins again.
  always_comb begin
    int unsigned idx;
    found        = 1'b0;
    winner       = last_grant;
    win_num      = '0;
    win_denom    = '0;
    win_by_frame = 1'b0;
    idx          = 0;
    for (int unsigned k = 1; k <= NS; k++) begin
      idx = (32'(last_grant) + k) % NS;
      if (!found && s_axis_tvalid[idx]) begin
        found        = 1'b1;
        winner       = IDX_W'(idx);
        win_num      = s_rate_num[idx*RATE_WIDTH +: RATE_WIDTH];
        win_denom    = s_rate_denom[idx*RATE_WIDTH +: RATE_WIDTH];
        win_by_frame = s_rate_by_frame[idx];
      end
    end
  end

  // Datapath mux is gated by grant_valid so reset removes ready/valid at once.
  always_comb begin
    s_axis_tready = '0;
    m_axis_tdata  = '0;
    m_axis_tkeep  = '0;
    m_axis_tvalid = 1'b0;
    m_axis_tlast  = 1'b0;
    m_axis_tid    = '0;
    m_axis_tdest  = '0;
    m_axis_tuser  = '0;
    for (int unsigned i = 0; i < NS; i++) begin
      if (grant_valid && grant_index == IDX_W'(i)) begin
        s_axis_tready[i] = m_axis_tready;
        m_axis_tdata     = s_axis_tdata[i*DATA_WIDTH +: DATA_WIDTH];
        m_axis_tkeep     = s_axis_tkeep[i*KEEP_WIDTH +: KEEP_WIDTH];
        m_axis_tvalid    = s_axis_tvalid[i];
        m_axis_tlast     = s_axis_tlast[i];
        m_axis_tid       = s_axis_tid[i*ID_WIDTH +: ID_WIDTH];
        m_axis_tdest     = s_axis_tdest[i*DEST_WIDTH +: DEST_WIDTH];
        m_axis_tuser     = s_axis_tuser[i*USER_WIDTH +: USER_WIDTH];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      grant_valid   <= 1'b0;
      grant_index   <= '0;
      last_grant    <= IDX_W'(S_COUNT - 1);
      rate_num      <= '0;
      rate_denom    <= '0;
      rate_by_frame <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (found) begin
            state         <= ACTIVE;
            grant_valid   <= 1'b1;
            grant_index   <= winner;
            last_grant    <= winner;
            rate_num      <= win_num;
            rate_denom    <= win_denom;
            rate_by_frame <= win_by_frame;
          end
        end
        ACTIVE: begin
          if (m_axis_tvalid && m_axis_tready && m_axis_tlast) begin
            state       <= IDLE;
            grant_valid <= 1'b0;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_axis_rate_limit_sched.sv
module tb_axis_rate_limit_sched;

  localparam int S  = 4;
  localparam int DW = 16;
  localparam int KW = 2;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic [S*DW-1:0] s_axis_tdata;
  logic [S*KW-1:0] s_axis_tkeep;
  logic [S-1:0]    s_axis_tvalid;
  logic [S-1:0]    s_axis_tready;
  logic [S-1:0]    s_axis_tlast;
  logic [S*8-1:0]  s_axis_tid;
  logic [S*8-1:0]  s_axis_tdest;
  logic [S-1:0]    s_axis_tuser;
  logic [S*8-1:0]  s_rate_num;
  logic [S*8-1:0]  s_rate_denom;
  logic [S-1:0]    s_rate_by_frame;
  logic [DW-1:0]   m_axis_tdata;
  logic [KW-1:0]   m_axis_tkeep;
  logic            m_axis_tvalid;
  logic            m_axis_tready;
  logic            m_axis_tlast;
  logic [7:0]      m_axis_tid;
  logic [7:0]      m_axis_tdest;
  logic [0:0]      m_axis_tuser;
  logic [7:0]      rate_num;
  logic [7:0]      rate_denom;
  logic            rate_by_frame;
  logic            grant_valid;
  logic [1:0]      grant_index;

  always #5 clk = ~clk;

  axis_rate_limit_sched #(
    .S_COUNT(S), .DATA_WIDTH(DW), .KEEP_WIDTH(KW), .ID_WIDTH(8),
    .DEST_WIDTH(8), .USER_WIDTH(1), .RATE_WIDTH(8)
  ) dut (
    .clk(clk), .rst(rst),
    .s_axis_tdata(s_axis_tdata), .s_axis_tkeep(s_axis_tkeep),
    .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
    .s_axis_tlast(s_axis_tlast), .s_axis_tid(s_axis_tid),
    .s_axis_tdest(s_axis_tdest), .s_axis_tuser(s_axis_tuser),
    .s_rate_num(s_rate_num), .s_rate_denom(s_rate_denom),
    .s_rate_by_frame(s_rate_by_frame),
    .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
    .m_axis_tlast(m_axis_tlast), .m_axis_tid(m_axis_tid),
    .m_axis_tdest(m_axis_tdest), .m_axis_tuser(m_axis_tuser),
    .rate_num(rate_num), .rate_denom(rate_denom), .rate_by_frame(rate_by_frame),
    .grant_valid(grant_valid), .grant_index(grant_index)
  );

  // Source model: each source offers quota[i] frames of len[i] beats;
  // tdata = {source, running sequence number}.
  int         quota [S];
  int         len   [S];
  int         seq   [S];
  int         beat  [S];
  bit         hold  [S];
  logic [7:0] rnum  [S];
  logic [7:0] rden  [S];
  bit         rbf   [S];

  typedef struct {
    int src;
    int sq;
    bit last;
    int c;
    int g;
    int tid;
  } beat_t;

  beat_t log_q[$];
  int checks     = 0;
  int errors     = 0;
  int cyc        = 0;
  int onehot_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic drive();
    for (int i = 0; i < S; i++) begin
      s_axis_tvalid[i]         = (quota[i] > 0) && !hold[i];
      s_axis_tdata[i*DW +: DW] = {4'(i), 12'(seq[i])};
      s_axis_tkeep[i*KW +: KW] = '1;
      s_axis_tlast[i]          = (beat[i] == len[i] - 1);
      s_axis_tid[i*8 +: 8]     = 8'(i + 16);
      s_axis_tdest[i*8 +: 8]   = 8'(i + 32);
      s_axis_tuser[i]          = 1'(i);
      s_rate_num[i*8 +: 8]     = rnum[i];
      s_rate_denom[i*8 +: 8]   = rden[i];
      s_rate_by_frame[i]       = rbf[i];
    end
    #1;
  endtask

  task automatic tick();
    logic [S-1:0] hs;
    beat_t b;
    hs = s_axis_tvalid & s_axis_tready;
    if (!$onehot0(s_axis_tready)) onehot_bad++;
    if (m_axis_tvalid && m_axis_tready) begin
      b.src  = int'(m_axis_tdata[15:12]);
      b.sq   = int'(m_axis_tdata[11:0]);
      b.last = m_axis_tlast;
      b.c    = cyc;
      b.g    = int'(grant_index);
      b.tid  = int'(m_axis_tid);
      log_q.push_back(b);
    end
    @(negedge clk);
    cyc++;
    for (int i = 0; i < S; i++) begin
      if (hs[i]) begin
        seq[i]++;
        if (beat[i] == len[i] - 1) begin
          beat[i] = 0;
          quota[i]--;
        end else begin
          beat[i]++;
        end
      end
    end
    drive();
  endtask

  function automatic bit all_done();
    for (int i = 0; i < S; i++) if (quota[i] > 0) return 1'b0;
    return 1'b1;
  endfunction

  task automatic run(input int max_cycles);
    int n = 0;
    while (!all_done() && n < max_cycles) begin
      tick();
      n++;
    end
    check("run_done", 32'(all_done()), 1);
  endtask

  task automatic clear_model();
    for (int i = 0; i < S; i++) begin
      quota[i] = 0; len[i] = 1; seq[i] = 0; beat[i] = 0; hold[i] = 0;
      rnum[i] = '0; rden[i] = '0; rbf[i] = 0;
    end
    log_q.delete();
    onehot_bad    = 0;
    m_axis_tready = 1'b1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clear_model();
    drive();
    @(negedge clk);
    rst = 1'b0;
    drive();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int exp_src  [6] = '{2, 2, 2, 2, 0, 0};
    int exp_sq   [6] = '{0, 1, 2, 3, 0, 1};
    bit exp_last [6] = '{0, 0, 0, 1, 0, 1};
    int hold_bad, rdy_bad, k;

    // Reset state
    clear_model();
    drive();
    rst = 1'b1;
    @(negedge clk);
    #1;
    check("rst_gv", 32'(grant_valid), 0);
    check("rst_gidx", 32'(grant_index), 0);
    check("rst_num", 32'(rate_num), 0);
    check("rst_den", 32'(rate_denom), 0);
    check("rst_rbf", 32'(rate_by_frame), 0);
    check("rst_srdy", 32'(s_axis_tready), 0);
    check("rst_mval", 32'(m_axis_tvalid), 0);
    rst = 1'b0;

    // Single 3-beat frame from source 2, rate 1/4
    quota[2] = 1; len[2] = 3; rnum[2] = 8'd1; rden[2] = 8'd4; rbf[2] = 1;
    drive();
    check("t1_idle_mval", 32'(m_axis_tvalid), 0);
    tick();
    check("t1_gv", 32'(grant_valid), 1);
    check("t1_gidx", 32'(grant_index), 2);
    check("t1_num", 32'(rate_num), 1);
    check("t1_den", 32'(rate_denom), 4);
    check("t1_rbf", 32'(rate_by_frame), 1);
    check("t1_srdy", 32'(s_axis_tready), 32'h4);
    check("t1_d0", 32'(m_axis_tdata), 32'h2000);
    check("t1_tid", 32'(m_axis_tid), 18);
    check("t1_tdest", 32'(m_axis_tdest), 34);
    tick();
    check("t1_d1", 32'(m_axis_tdata), 32'h2001);
    check("t1_last1", 32'(m_axis_tlast), 0);
    tick();
    check("t1_d2", 32'(m_axis_tdata), 32'h2002);
    check("t1_last2", 32'(m_axis_tlast), 1);
    tick();
    check("t1_gv_end", 32'(grant_valid), 0);
    check("t1_srdy_end", 32'(s_axis_tready), 0);
    check("t1_beats", 32'(log_q.size()), 3);

    // All four sources offering two 2-beat frames each
    do_reset();
    for (int i = 0; i < S; i++) begin quota[i] = 2; len[i] = 2; end
    drive();
    run(200);
    check("t2_beats", 32'(log_q.size()), 16);
    if (log_q.size() == 16) begin
      for (int f = 0; f < 8; f++) begin
        for (int b = 0; b < 2; b++) begin
          k = 2 * f + b;
          check("t2_src", 32'(log_q[k].src), 32'(f % 4));
          check("t2_gidx", 32'(log_q[k].g), 32'(f % 4));
          check("t2_seq", 32'(log_q[k].sq), 32'(2 * (f / 4) + b));
          check("t2_last", 32'(log_q[k].last), 32'(b));
          check("t2_tid", 32'(log_q[k].tid), 32'(f % 4 + 16));
        end
        check("t2_in_frame", 32'(log_q[2*f+1].c - log_q[2*f].c), 1);
        if (f > 0) check("t2_gap", 32'(log_q[2*f].c - log_q[2*f-1].c), 2);
      end
    end
    check("t2_onehot", 32'(onehot_bad), 0);

    // Rate change during a frame is ignored until the next grant
    do_reset();
    quota[1] = 2; len[1] = 3; rnum[1] = 8'd2; rden[1] = 8'd3;
    drive();
    tick();
    check("t3_gidx", 32'(grant_index), 1);
    check("t3_num_a", 32'(rate_num), 2);
    tick();
    rnum[1] = 8'd5;
    drive();
    check("t3_num_b", 32'(rate_num), 2);
    tick();
    check("t3_num_c", 32'(rate_num), 2);
    tick();
    check("t3_gv_idle", 32'(grant_valid), 0);
    check("t3_num_d", 32'(rate_num), 2);
    tick();
    check("t3_gv_regrant", 32'(grant_valid), 1);
    check("t3_gidx2", 32'(grant_index), 1);
    check("t3_num_e", 32'(rate_num), 5);
    check("t3_den_e", 32'(rate_denom), 3);
    run(50);
    check("t3_beats", 32'(log_q.size()), 6);

    // Backpressure toggling during a 4-beat frame from source 0
    do_reset();
    quota[0] = 1; len[0] = 4;
    drive();
    tick();
    hold_bad = 0;
    rdy_bad  = 0;
    for (int n = 0; n < 20 && quota[0] > 0; n++) begin
      m_axis_tready = (n % 2 == 0);
      drive();
      if (!grant_valid || grant_index != 2'd0) hold_bad++;
      if (s_axis_tready !== {3'b000, m_axis_tready}) rdy_bad++;
      tick();
    end
    m_axis_tready = 1'b1;
    check("t4_done", 32'(quota[0]), 0);
    check("t4_hold", 32'(hold_bad), 0);
    check("t4_rdy", 32'(rdy_bad), 0);
    check("t4_beats", 32'(log_q.size()), 4);
    if (log_q.size() == 4) begin
      for (int b = 0; b < 4; b++) begin
        check("t4_seq", 32'(log_q[b].sq), 32'(b));
        check("t4_last", 32'(log_q[b].last), 32'(b == 3));
        if (b > 0) check("t4_spacing", 32'(log_q[b].c - log_q[b-1].c), 2);
      end
    end

    // Asynchronous reset during beat 2 of a frame from source 3
    do_reset();
    quota[3] = 1; len[3] = 4; rnum[3] = 8'd7; rden[3] = 8'd9; rbf[3] = 1;
    drive();
    tick();
    check("t5_gidx", 32'(grant_index), 3);
    check("t5_num", 32'(rate_num), 7);
    tick();
    check("t5_mval", 32'(m_axis_tvalid), 1);
    check("t5_d1", 32'(m_axis_tdata), 32'h3001);
    rst = 1'b1;
    #1;
    check("t5_srdy", 32'(s_axis_tready), 0);
    check("t5_mval_rst", 32'(m_axis_tvalid), 0);
    check("t5_gv", 32'(grant_valid), 0);
    check("t5_num_rst", 32'(rate_num), 0);
    check("t5_den_rst", 32'(rate_denom), 0);
    check("t5_rbf_rst", 32'(rate_by_frame), 0);
    @(negedge clk);
    rst = 1'b0;
    quota[0] = 1; len[0] = 2;
    drive();
    tick();
    check("t5_regrant_gv", 32'(grant_valid), 1);
    check("t5_regrant_idx", 32'(grant_index), 0);

    // Granted source stalls mid-frame while source 0 waits
    do_reset();
    quota[2] = 1; len[2] = 4;
    drive();
    tick();
    tick();
    tick();
    hold[2]  = 1;
    quota[0] = 1; len[0] = 2;
    drive();
    for (int n = 0; n < 3; n++) begin
      check("t6_hold_gv", 32'(grant_valid), 1);
      check("t6_hold_idx", 32'(grant_index), 2);
      check("t6_hold_mval", 32'(m_axis_tvalid), 0);
      tick();
    end
    hold[2] = 0;
    drive();
    run(50);
    check("t6_beats", 32'(log_q.size()), 6);
    if (log_q.size() == 6) begin
      for (int b = 0; b < 6; b++) begin
        check("t6_src", 32'(log_q[b].src), 32'(exp_src[b]));
        check("t6_seq", 32'(log_q[b].sq), 32'(exp_sq[b]));
        check("t6_last", 32'(log_q[b].last), 32'(exp_last[b]));
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
